// File: rtl/sel0628_bus_arbiter_pkg.sv
// Shared types and constants for the SEL0628 two-master external bus arbiter.
package sel0628_bus_arbiter_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } state_e;

    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

    // On a tie, round-robin hands the bus to whichever port did not win last time.
    function automatic logic pick_owner(input logic a_req, input logic b_req,
                                        input logic last_owner, input logic fixed_prio);
        if (a_req && b_req) begin
            return fixed_prio ? OWNER_A : ~last_owner;
        end
        return b_req ? OWNER_B : OWNER_A;
    endfunction

endpackage

// File: rtl/sel0628_bus_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the memory pins.
// Handshake: a master raises x_req with stable x_we/x_addr/x_wdata and holds them until it
// samples x_ack=1 (a single-cycle pulse, x_rdata valid with it), then drops x_req on that edge.
interface sel0628_bus_arbiter_if;
    import sel0628_bus_arbiter_pkg::*;

    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_ack;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_ack;
    logic [DATA_W-1:0] b_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;
    logic              owner;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_ack, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_ack, b_rdata,
        output mem_addr, mem_we, mem_wdata,
        input  mem_rdata,
        output busy, owner
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_ack, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_ack, b_rdata,
        input  mem_addr, mem_we, mem_wdata,
        output mem_rdata,
        input  busy, owner
    );

endinterface

// File: rtl/sel0628_rr_arb2.sv
// Two-way grant decision plus the registered last-grantee pointer used for round-robin ties.
module sel0628_rr_arb2
    import sel0628_bus_arbiter_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic clk,
    input  logic clr_n,
    input  logic a_req_i,
    input  logic b_req_i,
    input  logic grant_stb_i,
    output logic grant_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        grant_o = pick_owner(a_req_i, b_req_i, last_q, FIXED_PRIO);
        last_d  = grant_stb_i ? grant_o : last_q;
    end

    // Pointer resets to "B granted last" so the first tie goes to A.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            last_q <= OWNER_B;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/sel0628_bus_arbiter.sv
// Serialises port A / port B accesses onto the SEL0628 memory pins, stretching each access
// by WAIT_CYCLES and returning read data with a one-cycle ack to the granted port.
module sel0628_bus_arbiter
    import sel0628_bus_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter bit FIXED_PRIO  = 1'b0
) (
    input  logic                  clk,
    input  logic                  clr_n,
    sel0628_bus_arbiter_if.slave  bus,
    output logic [1:0]            dbg_state_o
);

    localparam logic [CNT_W-1:0] WAIT_LOAD = WAIT_CYCLES[CNT_W-1:0];

    state_e            state_q,   state_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [DATA_W-1:0] wdata_q,   wdata_d;
    logic              we_q,      we_d;
    logic              owner_q,   owner_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

    logic any_req;
    logic grant_stb;
    logic grant;

    assign any_req   = bus.a_req | bus.b_req;
    assign grant_stb = (state_q == ST_IDLE) && any_req;

    sel0628_rr_arb2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_arb (
        .clk         (clk),
        .clr_n       (clr_n),
        .a_req_i     (bus.a_req),
        .b_req_i     (bus.b_req),
        .grant_stb_i (grant_stb),
        .grant_o     (grant)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            owner_q   <= OWNER_A;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            owner_q   <= owner_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        owner_d   = owner_q;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    owner_d = grant;
                    we_d    = (grant == OWNER_B) ? bus.b_we    : bus.a_we;
                    addr_d  = (grant == OWNER_B) ? bus.b_addr  : bus.a_addr;
                    wdata_d = (grant == OWNER_B) ? bus.b_wdata : bus.a_wdata;
                    cnt_d   = WAIT_LOAD;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    // Loaded on writes too; the requester ignores it in that case.
                    if (owner_q == OWNER_B) begin
                        b_rdata_d = bus.mem_rdata;
                    end else begin
                        a_rdata_d = bus.mem_rdata;
                    end
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // mem_we is decoded from the state register so an async reset drops it at once.
    always_comb begin
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.mem_we    = (state_q == ST_ACCESS) && we_q;
        bus.a_ack     = (state_q == ST_ACK) && (owner_q == OWNER_A);
        bus.b_ack     = (state_q == ST_ACK) && (owner_q == OWNER_B);
        bus.a_rdata   = a_rdata_q;
        bus.b_rdata   = b_rdata_q;
        bus.busy      = (state_q != ST_IDLE);
        bus.owner     = owner_q;
        dbg_state_o   = state_q;
    end

endmodule

// File: tb/tb_sel0628_bus_arbiter.sv
// Directed bench: three arbiter builds (WAIT=1 RR, WAIT=1 fixed prio, WAIT=0 RR), one exercised at a time.
module tb_sel0628_bus_arbiter;
    import sel0628_bus_arbiter_pkg::*;

    // ---- clock / reset ----
    logic clk   = 1'b0;
    logic clr_n = 1'b0;
    always #5 clk = ~clk;

    // ---- stimulus, routed to the DUT chosen by sel ----
    int                sel       = 0;
    logic              a_req     = 1'b0;
    logic              a_we      = 1'b0;
    logic [ADDR_W-1:0] a_addr    = '0;
    logic [DATA_W-1:0] a_wdata   = '0;
    logic              b_req     = 1'b0;
    logic              b_we      = 1'b0;
    logic [ADDR_W-1:0] b_addr    = '0;
    logic [DATA_W-1:0] b_wdata   = '0;
    logic [DATA_W-1:0] mem_rdata = '0;

    logic [2:0]        o_a_ack, o_b_ack, o_mem_we, o_busy, o_owner;
    logic [ADDR_W-1:0] o_mem_addr  [3];
    logic [DATA_W-1:0] o_mem_wdata [3];
    logic [DATA_W-1:0] o_a_rdata   [3];
    logic [DATA_W-1:0] o_b_rdata   [3];
    logic [1:0]        o_state     [3];

    sel0628_bus_arbiter_if bus [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign bus[g].a_req     = a_req && (sel == g);
        assign bus[g].a_we      = a_we;
        assign bus[g].a_addr    = a_addr;
        assign bus[g].a_wdata   = a_wdata;
        assign bus[g].b_req     = b_req && (sel == g);
        assign bus[g].b_we      = b_we;
        assign bus[g].b_addr    = b_addr;
        assign bus[g].b_wdata   = b_wdata;
        assign bus[g].mem_rdata = mem_rdata;

        sel0628_bus_arbiter #(
            .WAIT_CYCLES ((g == 2) ? 0 : 1),
            .FIXED_PRIO  (g == 1)
        ) u_dut (
            .clk         (clk),
            .clr_n       (clr_n),
            .bus         (bus[g]),
            .dbg_state_o (o_state[g])
        );

        assign o_a_ack[g]     = bus[g].a_ack;
        assign o_b_ack[g]     = bus[g].b_ack;
        assign o_mem_we[g]    = bus[g].mem_we;
        assign o_busy[g]      = bus[g].busy;
        assign o_owner[g]     = bus[g].owner;
        assign o_mem_addr[g]  = bus[g].mem_addr;
        assign o_mem_wdata[g] = bus[g].mem_wdata;
        assign o_a_rdata[g]   = bus[g].a_rdata;
        assign o_b_rdata[g]   = bus[g].b_rdata;
    end

    // ---- scoreboard ----
    int         n_vec = 0;
    int         n_err = 0;
    logic [0:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---- driver helpers ----
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        int we_cnt, b_acks, a_acks, n_pop, lat;
        logic [DATA_W-1:0] rd;

        // reset state
        sel = 0;
        repeat (2) tick();
        check("rst_busy",   o_busy[sel],     0);
        check("rst_we",     o_mem_we[sel],   0);
        check("rst_a_ack",  o_a_ack[sel],    0);
        check("rst_b_ack",  o_b_ack[sel],    0);
        check("rst_owner",  o_owner[sel],    0);
        check("rst_addr",   o_mem_addr[sel], 0);
        check("rst_state",  o_state[sel],    ST_IDLE);
        clr_n = 1'b1;
        tick();

        // 1: A read 0x2A, WAIT=1
        a_req = 1'b1; a_we = 1'b0; a_addr = 6'h2A; mem_rdata = 8'h5C;
        tick();
        check("t1_acc1_state", o_state[sel],    ST_ACCESS);
        check("t1_acc1_addr",  o_mem_addr[sel], 6'h2A);
        check("t1_acc1_we",    o_mem_we[sel],   0);
        check("t1_acc1_ack",   o_a_ack[sel],    0);
        tick();
        check("t1_acc2_addr",  o_mem_addr[sel], 6'h2A);
        check("t1_acc2_ack",   o_a_ack[sel],    0);
        tick();
        check("t1_ack",        o_a_ack[sel],    1);
        check("t1_rdata",      o_a_rdata[sel],  8'h5C);
        check("t1_b_ack",      o_b_ack[sel],    0);
        a_req = 1'b0;
        tick();
        check("t1_idle_ack",   o_a_ack[sel],    0);
        check("t1_idle_busy",  o_busy[sel],     0);
        check("t1_hold_addr",  o_mem_addr[sel], 6'h2A);

        // 2: B write 0x3F <= 0xA5
        b_req = 1'b1; b_we = 1'b1; b_addr = 6'h3F; b_wdata = 8'hA5; mem_rdata = 8'h11;
        we_cnt = 0; b_acks = 0; a_acks = 0;
        for (int c = 0; c < 7; c++) begin
            tick();
            if (o_mem_we[sel]) begin
                we_cnt++;
                check("t2_we_addr",  o_mem_addr[sel],  6'h3F);
                check("t2_we_wdata", o_mem_wdata[sel], 8'hA5);
            end
            if (o_a_ack[sel]) a_acks++;
            if (o_b_ack[sel]) begin
                b_acks++;
                check("t2_ack_we", o_mem_we[sel], 0);
                b_req = 1'b0;
            end
        end
        check("t2_we_width", we_cnt, 2);
        check("t2_b_acks",   b_acks, 1);
        check("t2_a_acks",   a_acks, 0);
        check("t2_owner",    o_owner[sel], 1);
        check("t2_hold_wd",  o_mem_wdata[sel], 8'hA5);
        b_we = 1'b0;

        // 3a: continuous tie, round-robin -> A,B,A,B
        exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
        a_req = 1'b1; b_req = 1'b1; a_addr = 6'h01; b_addr = 6'h02; mem_rdata = 8'h42;
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            tick();
            if (o_a_ack[sel] || o_b_ack[sel]) begin
                check("t3_one_ack", o_a_ack[sel] & o_b_ack[sel], 0);
                check("t3_rr_order", o_b_ack[sel], exp_q.pop_front());
            end
        end
        check("t3_rr_done", exp_q.size(), 0);
        a_req = 1'b0; b_req = 1'b0;
        tick();

        // 3b: fixed priority, A re-requests three times, then B
        sel = 1;
        exp_q = '{1'b0, 1'b0, 1'b0, 1'b1};
        n_pop = 0;
        a_req = 1'b1; b_req = 1'b1;
        for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
            tick();
            if (o_a_ack[sel] || o_b_ack[sel]) begin
                check("t3_fp_one_ack", o_a_ack[sel] & o_b_ack[sel], 0);
                check("t3_fp_order", o_b_ack[sel], exp_q.pop_front());
                n_pop++;
                if (n_pop == 3) a_req = 1'b0;
            end
        end
        check("t3_fp_done", exp_q.size(), 0);
        b_req = 1'b0;
        tick();

        // 4: reset mid-ACCESS of a write
        sel = 0;
        a_req = 1'b1; a_we = 1'b1; a_addr = 6'h10; a_wdata = 8'h77;
        tick();
        check("t4_we_before", o_mem_we[sel], 1);
        #3;
        clr_n = 1'b0; a_req = 1'b0; a_we = 1'b0;
        #1;
        check("t4_we_async",   o_mem_we[sel], 0);
        check("t4_busy_async", o_busy[sel],   0);
        check("t4_state",      o_state[sel],  ST_IDLE);
        @(posedge clk);
        #1;
        clr_n = 1'b1;
        a_acks = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (o_a_ack[sel]) a_acks++;
        end
        check("t4_no_ack", a_acks, 0);
        a_req = 1'b1; a_addr = 6'h05; mem_rdata = 8'h3C;
        lat = 0; rd = '0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (o_a_ack[sel]) begin
                lat = c; rd = o_a_rdata[sel]; a_req = 1'b0;
                break;
            end
        end
        check("t4_after_lat",   lat, 3);
        check("t4_after_rdata", rd,  8'h3C);
        tick();

        // 5: A drops request mid-ACCESS
        a_req = 1'b1; a_addr = 6'h07; mem_rdata = 8'h99;
        tick();
        check("t5_state", o_state[sel], ST_ACCESS);
        a_req = 1'b0;
        tick();
        tick();
        check("t5_ack",        o_a_ack[sel],   1);
        check("t5_rdata",      o_a_rdata[sel], 8'h99);
        tick();
        check("t5_ack_once",   o_a_ack[sel],   0);
        check("t5_idle",       o_state[sel],   ST_IDLE);
        tick();
        check("t5_no_restart", o_busy[sel],    0);

        // 6: WAIT=0 back-to-back reads 0x00, 0x01
        sel = 2;
        a_req = 1'b1; a_we = 1'b0; a_addr = 6'h00; mem_rdata = 8'hE1;
        tick();
        check("t6_r0_state", o_state[sel],    ST_ACCESS);
        check("t6_r0_we",    o_mem_we[sel],   0);
        check("t6_r0_ack0",  o_a_ack[sel],    0);
        tick();
        check("t6_r0_ack",   o_a_ack[sel],    1);
        check("t6_r0_rdata", o_a_rdata[sel],  8'hE1);
        a_req = 1'b0;
        tick();
        check("t6_gap_ack",  o_a_ack[sel],    0);
        a_req = 1'b1; a_addr = 6'h01; mem_rdata = 8'hE2;
        tick();
        check("t6_r1_addr",  o_mem_addr[sel], 6'h01);
        check("t6_r1_we",    o_mem_we[sel],   0);
        tick();
        check("t6_r1_ack",   o_a_ack[sel],    1);
        check("t6_r1_rdata", o_a_rdata[sel],  8'hE2);
        a_req = 1'b0;
        tick();
        check("t6_end_ack",  o_a_ack[sel],    0);
        tick();
        check("t6_no_double", o_busy[sel] | o_a_ack[sel], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
